joy_key_debounce_bank: RTL and testbench
========================================

Name: joy_key_debounce_bank

Overview:
- Front-end conditioning stage for the 5-way joystick (up, down, left, right, z) plus its centre press.
- Synchronises the raw active-low key pins to clk and debounces each key independently.
- Drives clean active-low levels straight into the downstream joystick/LED decoder, which consumes key_n_out unchanged.
- Also provides one-cycle press/release event pulses for future menu/counter logic.

Parameters:
- NKEYS, 5: number of keys. Bit order is up=0, down=1, left=2, right=3, z=4.
- DB_CYCLES, 1000000: consecutive stable samples needed to accept a level change (20 ms at 50 MHz). Legal range is 1 or more.
- REPEAT_DELAY, 25000000: hold time from a press pulse to the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 5000000: interval between subsequent auto-repeat pulses (optional feature only).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- key_n_in, input, NKEYS: raw key pins, active-low, asynchronous to clk.
- key_n_out, output, NKEYS: debounced level, active-low, registered.
- key_press, output, NKEYS: one-cycle pulse on debounced press (1 to 0 transition of key_n_out).
- key_release, output, NKEYS: one-cycle pulse on debounced release (0 to 1 transition).
- key_any, output, 1: high while any key_n_out bit is 0. Registered.

Behaviour:
- Decided: reset is asynchronous and active-low; clock is clk.
- Reset values:
  - Synchroniser flops all 1.
  - key_n_out all 1.
  - key_press, key_release and key_any all 0.
  - Debounce and repeat counters all 0.
- Synchroniser: 2 flip-flops per key, no other filtering.
- Per-key state is two stable states (UP, DOWN) plus a counter, cnt, of width $clog2(DB_CYCLES).
- Each edge, the synchronised sample s is compared with the stable level:
  - s equals stable level: cnt is cleared.
  - s differs and cnt == DB_CYCLES-1: stable level flips, cnt clears, and the matching press/release bit pulses high for exactly that cycle.
  - Otherwise: cnt increments.
- Latency:
  - Count the first edge that samples the new raw level as edge 1.
  - key_n_out changes on edge DB_CYCLES+2.
  - The press/release pulse is coincident with that change.
  - key_any updates on the same edge.
- Glitches:
  - A glitch or bounce shorter than DB_CYCLES synchronised samples produces no output change and no pulse.
  - Any return to the stable level restarts the count from 0.
- With DB_CYCLES=1, the output follows the synchroniser delayed by one edge.
- Keys are fully independent: simultaneous changes on several keys produce simultaneous pulses. The block applies no priority; priority is the consumer's job.
- key_press and key_release are never high together on the same bit.
- Reset asserted mid-count: everything returns to reset values immediately. After release, a key still held low is re-accepted as a new press after the full latency.

Optional Feature:
- Macro: JOY_AUTOREPEAT_EN.
- Defined:
  - Each key has a hold counter that runs only while key_n_out is 0.
  - The first repeat key_press pulse comes REPEAT_DELAY edges after the initial press pulse.
  - Further pulses follow every REPEAT_PERIOD edges while the key stays held.
  - Release or reset clears the hold counter; no key_release pulse is generated for repeats.
- Not defined:
  - Exactly one key_press pulse per debounced press.
  - REPEAT_DELAY and REPEAT_PERIOD are accepted but unused, and no hold counters are synthesised.

Decomposition:
- Package joy_pkg holds:
  - NKEYS default.
  - Key index constants KEY_UP=0, KEY_DOWN=1, KEY_LEFT=2, KEY_RIGHT=3, KEY_Z=4.
  - Default cycle constants for 50 MHz.
- Sub-module joy_key_filter: a single-key synchroniser, debouncer and optional repeat unit, instantiated NKEYS times in a generate loop.
- key_any is an OR-reduce register in the top module.

Test Plan:
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset and idle: assert reset with key_n_in=5'b00000, then release with all pins high → key_n_out=5'b11111 and no pulses for 50 cycles.
- Bounce rejection: key_n_in[0] low for 3 cycles, high 2 cycles, low 3 cycles, then high → key_n_out[0] stays 1 and key_press stays 0.
- Clean press/release: key_n_in[3] low from edge 1 → key_n_out[3]=0 and key_press[3]=1 at edge 6 only. Raise it → key_release[3] one pulse 6 edges later, and key_any falls on the same edge.
- Simultaneous keys: key_n_in[1] and key_n_in[4] fall on the same edge → both outputs and both press pulses appear on the same edge. key_n_out=5'b01101.
- Reset mid-count: key_n_in[2] low, assert reset at edge 3, release at edge 5 while still low → no pulse before reset. Press accepted DB_CYCLES+2 edges after the first post-reset sampling edge.
- Auto-repeat (macro defined): hold key 0 → press pulses at edges t, t+10, t+13, t+16, … until release. With the macro undefined → single pulse at t.

Source files
------------

// File: rtl/joy_pkg.sv
// -----------------------------------------------------------------------------
// joy_pkg
// Shared constants and types for the joystick key conditioning slice.
//   - JOY_NKEYS            : default key count (up, down, left, right, z)
//   - KEY_UP .. KEY_Z      : bit positions of each key in the key vectors
//   - JOY_DB_CYCLES        : 20 ms debounce at 50 MHz
//   - JOY_REPEAT_DELAY     : 500 ms hold before first auto-repeat at 50 MHz
//   - JOY_REPEAT_PERIOD    : 100 ms auto-repeat interval at 50 MHz
//   - key_state_t          : stable debounced level of one key
//   - cnt_width / max_int  : counter sizing helpers
// -----------------------------------------------------------------------------
package joy_pkg;

    localparam int JOY_NKEYS = 5;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_Z     = 4;

    localparam int JOY_DB_CYCLES     = 1000000;
    localparam int JOY_REPEAT_DELAY  = 25000000;
    localparam int JOY_REPEAT_PERIOD = 5000000;

    typedef enum logic {
        KEY_ST_UP   = 1'b0,
        KEY_ST_DOWN = 1'b1
    } key_state_t;

    // Width of a counter that must reach n-1; never narrower than one bit so
    // that n == 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/joy_key_filter.sv
// -----------------------------------------------------------------------------
// joy_key_filter
// Single-key conditioning: 2-flop synchroniser, debouncer with a stable
// UP/DOWN state and a consecutive-sample counter, plus an optional
// auto-repeat unit enabled by the JOY_AUTOREPEAT_EN macro.
//
// Ports:
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   key_n_in     : raw key pin, active-low, asynchronous to clk
//   key_n_out    : debounced level, active-low, registered
//   key_n_next   : value key_n_out takes on the next edge (combinational),
//                  lets the parent register derived flags on the same edge
//   key_press    : one-cycle pulse on debounced press (and on auto-repeat)
//   key_release  : one-cycle pulse on debounced release
// -----------------------------------------------------------------------------
module joy_key_filter
    import joy_pkg::*;
#(
    parameter int DB_CYCLES     = JOY_DB_CYCLES,
    parameter int REPEAT_DELAY  = JOY_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = JOY_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_in,
    output logic key_n_out,
    output logic key_n_next,
    output logic key_press,
    output logic key_release
);

    localparam int              CNT_W   = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    key_state_t       state_r;
    key_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             key_n_r;
    logic             press_r;
    logic             release_r;
    logic             press_nxt_s;
    logic             release_nxt_s;
    logic             rep_pulse_s;

    // Two-flop synchroniser; idles high so a released key looks inactive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n_in;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state: a level change is accepted only after DB_CYCLES
    // consecutive differing samples; any agreeing sample restarts the count.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        case (state_r)
            KEY_ST_UP: begin
                if (!sync2_r) begin
                    if (cnt_r == DB_LAST) begin
                        state_nxt_s = KEY_ST_DOWN;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        press_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            KEY_ST_DOWN: begin
                if (sync2_r) begin
                    if (cnt_r == DB_LAST) begin
                        state_nxt_s   = KEY_ST_UP;
                        cnt_nxt_s     = {CNT_W{1'b0}};
                        release_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s = KEY_ST_UP;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

`ifdef JOY_AUTOREPEAT_EN
    localparam int                HOLD_W     = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PER_LAST   = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
    logic              first_done_r;
    logic              first_done_nxt_s;

    // Hold timer: runs only while the key stays down across the edge, so the
    // press edge itself and the release edge both restart it.
    always_comb begin
        hold_cnt_nxt_s   = hold_cnt_r;
        first_done_nxt_s = first_done_r;
        rep_pulse_s      = 1'b0;
        if ((state_r == KEY_ST_DOWN) && (state_nxt_s == KEY_ST_DOWN)) begin
            if (!first_done_r) begin
                if (hold_cnt_r == DELAY_LAST) begin
                    rep_pulse_s      = 1'b1;
                    hold_cnt_nxt_s   = {HOLD_W{1'b0}};
                    first_done_nxt_s = 1'b1;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                end
            end else begin
                if (hold_cnt_r == PER_LAST) begin
                    rep_pulse_s    = 1'b1;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
        end else begin
            hold_cnt_nxt_s   = {HOLD_W{1'b0}};
            first_done_nxt_s = 1'b0;
        end
    end

    // Hold timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_r   <= {HOLD_W{1'b0}};
            first_done_r <= 1'b0;
        end else begin
            hold_cnt_r   <= hold_cnt_nxt_s;
            first_done_r <= first_done_nxt_s;
        end
    end
`else
    assign rep_pulse_s = 1'b0;
`endif

    // Debounce state, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= KEY_ST_UP;
            cnt_r     <= {CNT_W{1'b0}};
            key_n_r   <= 1'b1;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            key_n_r   <= (state_nxt_s == KEY_ST_UP);
            press_r   <= press_nxt_s | rep_pulse_s;
            release_r <= release_nxt_s;
        end
    end

    assign key_n_out   = key_n_r;
    assign key_n_next  = (state_nxt_s == KEY_ST_UP);
    assign key_press   = press_r;
    assign key_release = release_r;

endmodule

// File: rtl/joy_key_debounce_bank.sv
// -----------------------------------------------------------------------------
// joy_key_debounce_bank
// Front-end conditioning for the 5-way joystick: synchronises and debounces
// each active-low key independently and produces press/release pulses.
// Optional auto-repeat on held keys when JOY_AUTOREPEAT_EN is defined.
//
// Ports:
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   key_n_in     : raw key pins [NKEYS], active-low (up=0 down=1 left=2
//                  right=3 z=4)
//   key_n_out    : debounced levels [NKEYS], active-low, registered
//   key_press    : one-cycle press pulses [NKEYS]
//   key_release  : one-cycle release pulses [NKEYS]
//   key_any      : registered, high while any debounced key is down
// -----------------------------------------------------------------------------
module joy_key_debounce_bank
    import joy_pkg::*;
#(
    parameter int NKEYS         = JOY_NKEYS,
    parameter int DB_CYCLES     = JOY_DB_CYCLES,
    parameter int REPEAT_DELAY  = JOY_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = JOY_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_n_in,
    output logic [NKEYS-1:0] key_n_out,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic             key_any
);

    logic [NKEYS-1:0] key_n_next_s;
    logic             key_any_r;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        joy_key_filter #(
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_filter (
            .clk         (clk),
            .reset       (reset),
            .key_n_in    (key_n_in[i]),
            .key_n_out   (key_n_out[i]),
            .key_n_next  (key_n_next_s[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

    // key_any is built from next-state levels so it changes on the same edge
    // as key_n_out rather than one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_any_r <= 1'b0;
        end else begin
            key_any_r <= |(~key_n_next_s);
        end
    end

    assign key_any = key_any_r;

endmodule

// File: tb/tb_joy_key_debounce_bank.sv
module tb_joy_key_debounce_bank;

    localparam int NK  = 5;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
`ifdef JOY_AUTOREPEAT_EN
    localparam bit REP_EN    = 1'b1;
    localparam int HOLD_PRESSES = 8;
`else
    localparam bit REP_EN    = 1'b0;
    localparam int HOLD_PRESSES = 1;
`endif

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_n_in;
    logic [NK-1:0] key_n_out;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          key_any;

    int checks;
    int errors;

    // Reference model state: history of raw inputs per sampling edge since
    // reset, accepted level, edge of last acceptance, edge of last press.
    logic [NK-1:0] rawh [$];
    int            edge_n;
    logic [NK-1:0] m_level;
    int            last_flip [NK];
    int            t_press [NK];
    logic [NK-1:0] e_press;
    logic [NK-1:0] e_release;

    joy_key_debounce_bank #(
        .NKEYS         (NK),
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n_in    (key_n_in),
        .key_n_out   (key_n_out),
        .key_press   (key_press),
        .key_release (key_release),
        .key_any     (key_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NK-1:0] raw_at(input int e);
        if (e < 1 || e > rawh.size()) begin
            return '1;
        end
        return rawh[e-1];
    endfunction

    task automatic model_reset();
        rawh.delete();
        edge_n  = 0;
        m_level = '1;
        for (int k = 0; k < NK; k++) begin
            last_flip[k] = -1000;
            t_press[k]   = -1000;
        end
    endtask

    // A key's accepted level flips on edge n when the DB raw values sampled
    // on edges n-1-DB .. n-2 (two-flop delay) all differ from it and all
    // postdate the previous acceptance.
    task automatic model_edge();
        logic flip;
        int   d;
        e_press   = '0;
        e_release = '0;
        for (int k = 0; k < NK; k++) begin
            flip = (edge_n - last_flip[k] >= DB);
            for (int j = edge_n - 1 - DB; j <= edge_n - 2; j++) begin
                if (raw_at(j)[k] == m_level[k]) flip = 1'b0;
            end
            if (flip) begin
                last_flip[k] = edge_n;
                if (m_level[k]) begin
                    e_press[k] = 1'b1;
                    t_press[k] = edge_n;
                end else begin
                    e_release[k] = 1'b1;
                end
                m_level[k] = ~m_level[k];
            end else if (REP_EN && !m_level[k]) begin
                d = edge_n - t_press[k];
                if (d == RD || (d > RD && ((d - RD) % RP) == 0)) e_press[k] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_n, got, exp);
        end
    endtask

    task automatic chk_all();
        chk("key_n_out", key_n_out, m_level);
        chk("key_press", key_press, e_press);
        chk("key_release", key_release, e_release);
        chk("key_any", {4'b0000, key_any}, {4'b0000, ~&m_level});
    endtask

    // Called at a negedge: drive v, take one rising edge, model it, check.
    task automatic step(input logic [NK-1:0] v);
        key_n_in = v;
        @(posedge clk);
        edge_n++;
        rawh.push_back(v);
        model_edge();
        #1;
        chk_all();
        @(negedge clk);
    endtask

    // Called at a negedge: assert reset, hold for n edges, release at a negedge.
    task automatic do_reset(input logic [NK-1:0] v, input int n);
        reset    = 1'b0;
        key_n_in = v;
        #1;
        chk("rst_key_n_out", key_n_out, 5'b11111);
        chk("rst_press", key_press | key_release, 5'b00000);
        chk("rst_any", {4'b0000, key_any}, 5'b00000);
        repeat (n) @(posedge clk);
        #1;
        chk("rst_hold_key_n_out", key_n_out, 5'b11111);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int            npress;
        int            left [NK];
        logic [NK-1:0] rv;

        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        key_n_in = '1;
        model_reset();
        @(negedge clk);

        // Reset and idle
        do_reset(5'b00000, 3);
        repeat (50) step(5'b11111);

        // Bounce rejection on key 0
        repeat (3) step(5'b11110);
        repeat (2) step(5'b11111);
        repeat (3) step(5'b11110);
        repeat (8) step(5'b11111);
        chk("bounce_level", key_n_out, 5'b11111);

        // Clean press/release on key 3
        repeat (5) step(5'b10111);
        chk("k3_before", key_n_out, 5'b11111);
        step(5'b10111);
        chk("k3_press", key_press, 5'b01000);
        chk("k3_level", key_n_out, 5'b10111);
        step(5'b10111);
        chk("k3_press_once", key_press, 5'b00000);
        step(5'b10111);
        repeat (5) step(5'b11111);
        chk("k3_still_down", key_n_out, 5'b10111);
        step(5'b11111);
        chk("k3_release", key_release, 5'b01000);
        chk("k3_any_fall", {4'b0000, key_any}, 5'b00000);
        repeat (4) step(5'b11111);

        // Simultaneous keys 1 and 4
        repeat (5) step(5'b01101);
        step(5'b01101);
        chk("sim_level", key_n_out, 5'b01101);
        chk("sim_press", key_press, 5'b10010);
        repeat (2) step(5'b01101);
        repeat (8) step(5'b11111);

        // Reset mid-count on key 2
        repeat (2) step(5'b11011);
        do_reset(5'b11011, 2);
        repeat (5) step(5'b11011);
        chk("rst_mid_nopulse", key_n_out, 5'b11111);
        step(5'b11011);
        chk("rst_mid_press", key_press, 5'b00100);
        repeat (8) step(5'b11111);

        // Auto-repeat on held key 0 (single pulse without the feature)
        npress = 0;
        for (int i = 0; i < 38; i++) begin
            step((i < 30) ? 5'b11110 : 5'b11111);
            if (key_press[0]) npress++;
        end
        checks++;
        assert (npress === HOLD_PRESSES) else begin
            errors++;
            $error("FAIL hold_press_count: observed %0d expected %0d", npress, HOLD_PRESSES);
        end

        // Randomised bouncing on all keys
        rv = '1;
        for (int k = 0; k < NK; k++) left[k] = 1;
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NK; k++) begin
                left[k]--;
                if (left[k] <= 0) begin
                    rv[k]   = ~rv[k];
                    left[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 16))
                                                          : int'($urandom_range(1, 5));
                end
            end
            step(rv);
        end
        repeat (12) step(5'b11111);
        chk("final_idle", key_n_out, 5'b11111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
